// File: rtl/cluster_cmd_dispatch_pkg.sv
// Shared constants for the cluster command dispatcher.
// FSM encodings are gray-coded along the main visit path.
package cluster_cmd_dispatch_pkg;

  localparam int NCL       = 8;
  localparam int IDX_W     = 3;
  localparam int ROW_W     = 16;
  localparam int COL_W     = 14;
  localparam int COL_SHIFT = 6;
  localparam int TIMEOUT   = 31;
  localparam int TMO_W     = 5;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_SEL   = 3'b001;
  localparam logic [2:0] S_REQ   = 3'b011;
  localparam logic [2:0] S_WAIT  = 3'b010;
  localparam logic [2:0] S_ISSUE = 3'b110;
  localparam logic [2:0] S_DONE  = 3'b111;

  function automatic logic [IDX_W-1:0] idx_next(
    input logic [IDX_W-1:0] idx,
    input logic [IDX_W-1:0] num
  );
    return (idx == num) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/cluster_cmd_dispatch_addr_calc.sv
// Registered DDR byte address: base + row*stride + (col << COL_SHIFT).
// Sum wraps modulo 2^32.
module ddr_addr_calc
  import cluster_cmd_dispatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [31:0]      i_base,
  input  logic [15:0]      i_stride,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic [31:0]      o_addr
);

  logic [31:0] w_prod;
  logic [31:0] w_coff;
  logic [31:0] r_addr;

  assign w_prod = {16'b0, i_row} * {16'b0, i_stride};
  assign w_coff = {{(32-COL_W-COL_SHIFT){1'b0}}, i_col,
                   {COL_SHIFT{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_addr <= '0;
    else if (i_en)
      r_addr <= i_base + w_prod + w_coff;
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/cluster_cmd_dispatch.sv
// Round-robin sequencer: requests positions from clusters and
// issues one DDR command per answered request.
module cluster_cmd_dispatch
  import cluster_cmd_dispatch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 channel_period_en,
  input  logic                 cfg_valid_i,
  input  logic [IDX_W-1:0]     cfg_cluster_num_i,
  input  logic [31:0]          cfg_base_addr_i,
  input  logic [15:0]          cfg_row_stride_i,
  input  logic [7:0]           cfg_burst_len_i,
  output logic [NCL-1:0]       cluster_req_o,
  input  logic [NCL-1:0]       cluster_request_allow_i,
  input  logic [NCL-1:0]       cluster_release_allow_i,
  input  logic [NCL*ROW_W-1:0] cluster_pos_row_i,
  input  logic [NCL*COL_W-1:0] cluster_pos_col_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [31:0]          cmd_addr_o,
  output logic [7:0]           cmd_len_o,
  output logic [IDX_W-1:0]     cmd_cluster_id_o,
  output logic                 channel_done_o,
  output logic                 err_timeout_o
);

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_num;
  logic [31:0]      r_base;
  logic [15:0]      r_stride;
  logic [7:0]       r_len;
  logic [NCL-1:0]   r_rel;
  logic             r_relf;
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  logic [ROW_W-1:0] w_rows [NCL];
  logic [COL_W-1:0] w_cols [NCL];
  logic [NCL-1:0]   w_act;
  logic [NCL-1:0]   w_rel;
  logic             w_all;
  logic             w_cap;
  logic [IDX_W-1:0] w_nxt;

  always_comb begin
    for (int i = 0; i < NCL; i++) begin
      w_rows[i] = cluster_pos_row_i[ROW_W*i +: ROW_W];
      w_cols[i] = cluster_pos_col_i[COL_W*i +: COL_W];
    end
  end

  // A slot is done if its calculator says so or its last command said so.
  assign w_act = 8'hFF >> (3'd7 - r_num);
  assign w_rel = cluster_release_allow_i | r_rel;
  assign w_all = &(w_rel | ~w_act);
  assign w_nxt = idx_next(r_idx, r_num);
  assign w_cap = (r_state == S_WAIT) &&
                 cluster_request_allow_i[r_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num    <= '0;
      r_base   <= '0;
      r_stride <= '0;
      r_len    <= '0;
    end else if (cfg_valid_i) begin
      r_num    <= cfg_cluster_num_i;
      r_base   <= cfg_base_addr_i;
      r_stride <= cfg_row_stride_i;
      r_len    <= cfg_burst_len_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !channel_period_en) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rel   <= '0;
      r_relf  <= 1'b0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else if (cfg_valid_i) begin
      r_state <= S_SEL;
      r_idx   <= '0;
      r_rel   <= '0;
      r_relf  <= 1'b0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_SEL: begin
          if (w_all)
            r_state <= S_DONE;
          else if (w_rel[r_idx])
            r_idx <= w_nxt;
          else
            r_state <= S_REQ;
        end
        S_REQ: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_cap) begin
            r_relf  <= cluster_release_allow_i[r_idx];
            r_state <= S_ISSUE;
          end else if (r_tmo == TMO_W'(TIMEOUT)) begin
            r_err   <= 1'b1;
            r_idx   <= w_nxt;
            r_state <= S_SEL;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_ISSUE: begin
          if (cmd_ready_i) begin
            if (r_relf)
              r_rel[r_idx] <= 1'b1;
            r_idx   <= w_nxt;
            r_state <= S_SEL;
          end
        end
        S_IDLE, S_DONE: r_state <= r_state;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  ddr_addr_calc u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_cap),
    .i_base   (r_base),
    .i_stride (r_stride),
    .i_row    (w_rows[r_idx]),
    .i_col    (w_cols[r_idx]),
    .o_addr   (cmd_addr_o)
  );

  assign cluster_req_o = (r_state == S_REQ) ?
    ({{(NCL-1){1'b0}}, 1'b1} << r_idx) : '0;
  assign cmd_valid_o      = (r_state == S_ISSUE);
  assign channel_done_o   = (r_state == S_DONE);
  assign cmd_len_o        = r_len;
  assign cmd_cluster_id_o = r_idx;
  assign err_timeout_o    = r_err;

endmodule

// File: tb/tb_cluster_cmd_dispatch.sv
// Directed bench for cluster_cmd_dispatch.
// Drives and samples 1 time unit after each rising edge.
module tb_cluster_cmd_dispatch;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         cfg_v;
  logic [2:0]   cfg_num;
  logic [31:0]  cfg_base;
  logic [15:0]  cfg_stride;
  logic [7:0]   cfg_len;
  logic [7:0]   req;
  logic [7:0]   alw;
  logic [7:0]   rel;
  logic [127:0] row_bus;
  logic [111:0] col_bus;
  logic         cmd_v;
  logic         rdy;
  logic [31:0]  addr;
  logic [7:0]   len;
  logic [2:0]   cid;
  logic         done;
  logic         err;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] cur_len;

  always #5 clk = ~clk;

  cluster_cmd_dispatch dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .channel_period_en       (en),
    .cfg_valid_i             (cfg_v),
    .cfg_cluster_num_i       (cfg_num),
    .cfg_base_addr_i         (cfg_base),
    .cfg_row_stride_i        (cfg_stride),
    .cfg_burst_len_i         (cfg_len),
    .cluster_req_o           (req),
    .cluster_request_allow_i (alw),
    .cluster_release_allow_i (rel),
    .cluster_pos_row_i       (row_bus),
    .cluster_pos_col_i       (col_bus),
    .cmd_valid_o             (cmd_v),
    .cmd_ready_i             (rdy),
    .cmd_addr_o              (addr),
    .cmd_len_o               (len),
    .cmd_cluster_id_o        (cid),
    .channel_done_o          (done),
    .err_timeout_o           (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] num, input logic [31:0] base,
                     input logic [15:0] stride, input logic [7:0] l);
    en = 1'b1;
    cfg_num = num;
    cfg_base = base;
    cfg_stride = stride;
    cfg_len = l;
    cur_len = l;
    cfg_v = 1'b1;
    step();
    cfg_v = 1'b0;
  endtask

  task automatic wait_req(input int exp_idx);
    int n = 0;
    logic [7:0] want;
    want = 8'b1 << exp_idx;
    while (req == 8'h00 && n < 100) begin
      step();
      n++;
    end
    check("req_idx", {24'b0, req}, {24'b0, want});
    check("req_onehot", {31'b0, $onehot(req)}, 32'd1);
    check("req_no_cmd", {31'b0, cmd_v}, 32'd0);
  endtask

  task automatic answer(input int idx, input int dly,
                        input logic [15:0] r, input logic [13:0] c,
                        input logic rl);
    repeat (dly) step();
    row_bus[16*idx +: 16] = r;
    col_bus[14*idx +: 14] = c;
    if (rl) rel[idx] = 1'b1;
    alw[idx] = 1'b1;
    step();
    alw = '0;
  endtask

  task automatic wait_cmd(input logic [31:0] a, input int id,
                          input bit hold);
    int n = 0;
    while (!cmd_v && n < 50) begin
      step();
      n++;
    end
    check("cmd_valid", {31'b0, cmd_v}, 32'd1);
    check("cmd_addr", addr, a);
    check("cmd_id", {29'b0, cid}, id[31:0]);
    check("cmd_len", {24'b0, len}, {24'b0, cur_len});
    if (!hold) begin
      rdy = 1'b1;
      step();
      rdy = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    bit saw;
    int n;
    rst_n = 0; en = 0; cfg_v = 0; cfg_num = 0;
    cfg_base = 0; cfg_stride = 0; cfg_len = 0; cur_len = 0;
    alw = 0; rel = 0; row_bus = 0; col_bus = 0; rdy = 0;
    step();
    step();
    check("rst_req", {24'b0, req}, 32'd0);
    check("rst_valid", {31'b0, cmd_v}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_len", {24'b0, len}, 32'd0);
    check("rst_id", {29'b0, cid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1;
    step();

    // single cluster
    cfg(3'd0, 32'h1000, 16'h200, 8'h10);
    wait_req(0);
    answer(0, 10, 16'd3, 14'd2, 1'b0);
    wait_cmd(32'h1680, 0, 0);

    // round robin, ready held high
    rdy = 1'b1;
    cfg(3'd2, 32'h0, 16'h100, 8'h04);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = k % 3;
      wait_req(i);
      answer(i, 2, 16'(i + 1), 14'(i), 1'b0);
      wait_cmd(32'((i + 1) * 256 + i * 64), i, 1);
    end
    rdy = 1'b0;

    // backpressure
    cfg(3'd0, 32'h2000, 16'h40, 8'h20);
    wait_req(0);
    answer(0, 1, 16'd5, 14'd7, 1'b0);
    wait_cmd(32'h2300, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", {31'b0, cmd_v}, 32'd1);
      check("bp_addr", addr, 32'h2300);
      check("bp_req", {24'b0, req}, 32'd0);
    end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check("bp_accept", {31'b0, cmd_v}, 32'd0);

    // skip masked slot, done after releases
    rel = 8'b0000_0010;
    cfg(3'd2, 32'h0, 16'h10, 8'h01);
    wait_req(0);
    check("done_early", {31'b0, done}, 32'd0);
    answer(0, 1, 16'd1, 14'd1, 1'b1);
    wait_cmd(32'h50, 0, 0);
    wait_req(2);
    answer(2, 1, 16'd2, 14'd0, 1'b1);
    check("done_pre", {31'b0, done}, 32'd0);
    wait_cmd(32'h20, 2, 0);
    n = 0;
    while (!done && n < 5) begin
      step();
      n++;
    end
    check("done", {31'b0, done}, 32'd1);
    step();
    check("done_hold", {31'b0, done}, 32'd1);
    check("done_req", {24'b0, req}, 32'd0);

    // timeout on cluster 1
    rel = '0;
    cfg(3'd2, 32'h0, 16'h10, 8'h01);
    check("done_clr", {31'b0, done}, 32'd0);
    wait_req(0);
    answer(0, 1, 16'd0, 14'd1, 1'b0);
    wait_cmd(32'h40, 0, 0);
    wait_req(1);
    saw = 0;
    repeat (20) begin
      step();
      saw |= cmd_v;
    end
    check("tmo_early", {31'b0, err}, 32'd0);
    n = 0;
    while (!err && n < 30) begin
      step();
      saw |= cmd_v;
      n++;
    end
    check("tmo_err", {31'b0, err}, 32'd1);
    check("tmo_no_cmd", {31'b0, saw}, 32'd0);
    wait_req(2);
    check("tmo_sticky", {31'b0, err}, 32'd1);
    cfg(3'd0, 32'h0, 16'h10, 8'h01);
    check("tmo_clr", {31'b0, err}, 32'd0);

    // address wrap, then abort during ISSUE
    cfg(3'd0, 32'hFFFF_FF00, 16'h200, 8'h08);
    wait_req(0);
    answer(0, 1, 16'd1, 14'd0, 1'b0);
    wait_cmd(32'h0000_0100, 0, 1);
    en = 1'b0;
    step();
    check("abort_valid", {31'b0, cmd_v}, 32'd0);
    check("abort_req", {24'b0, req}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    repeat (3) step();
    check("idle_req", {24'b0, req}, 32'd0);
    check("idle_valid", {31'b0, cmd_v}, 32'd0);
    en = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
